// File: rtl/store_buffer_pkg.sv
// Shared store-buffer entry layout and memory-op encodings.
// Entry layout: {op[2:0], addr[31:0]}.
package storeBufPkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned OP_W        = 3;
  localparam int unsigned ENTRY_W     = OP_W + ADDR_W;
  localparam int unsigned WORD_ADDR_W = ADDR_W - 2;

  typedef enum logic [OP_W-1:0] {
    OpByte = 3'b000,
    OpHalf = 3'b001,
    OpWord = 3'b010
  } mem_op_e;

endpackage

// File: rtl/store_buffer_sb_match.sv
// Associative load-address compare over valid store-buffer entries.
// Walks oldest to youngest so the youngest matching word store wins.
module sbMatch
  import storeBufPkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned EW    = ENTRY_W,
  parameter int unsigned DW    = 32,
  parameter int unsigned PW    = $clog2(DEPTH),
  parameter int unsigned CW    = PW + 1
) (
  input  logic [DEPTH-1:0][EW-1:0] addrs,
  input  logic [DEPTH-1:0][DW-1:0] datas,
  input  logic [PW-1:0]            rd_ptr,
  input  logic [CW-1:0]            count,
  input  logic [WORD_ADDR_W-1:0]   load_addr,
  output logic                     hit,
  output logic [DW-1:0]            data
);

  logic [PW-1:0] idx;
  logic [1:0]    unused_byte_bits;

  always_comb begin
    hit              = 1'b0;
    data             = '0;
    idx              = '0;
    unused_byte_bits = '0;
    for (int i = 0; i < DEPTH; i++) begin
      unused_byte_bits = unused_byte_bits ^ addrs[i][1:0];
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) &&
          (addrs[idx][ADDR_W +: OP_W] == OpWord) &&
          (addrs[idx][ADDR_W-1:2] == load_addr)) begin
        hit  = 1'b1;
        data = datas[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular FIFO of committed stores awaiting cache write.
// Store-to-load forwarding is compiled in only when STORE_BUF_FWD_EN is defined.
module store_buffer
  import storeBufPkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned EW    = ENTRY_W,
  parameter int unsigned DW    = 32
) (
  input  logic                     Phi1,
  input  logic                     Reset_s1,
  input  logic                     pushStore_s1,
  input  logic [EW-1:0]            pushAddr_s1,
  input  logic [DW-1:0]            pushData_s1,
  input  logic                     popStoreBuffer_s1,
  output logic [EW-1:0]            storeBufAddr_s1w,
  output logic [DW-1:0]            storeBufData_s1w,
  output logic                     sbEmpty_s1,
  output logic                     sbFull_s1,
  output logic [$clog2(DEPTH):0]   sbCount_s1,
  output logic                     sbOverflow_s1,
  input  logic [WORD_ADDR_W-1:0]   loadAddr_s1,
  output logic                     fwdHit_s1,
  output logic [DW-1:0]            fwdData_s1
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0][EW-1:0] addr_mem;
  logic [DEPTH-1:0][DW-1:0] data_mem;

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          do_push, do_pop;

  assign sbEmpty_s1    = (count_q == '0);
  assign sbFull_s1     = (count_q == CW'(DEPTH));
  assign sbCount_s1    = count_q;
  assign sbOverflow_s1 = overflow_q;

  assign do_pop  = popStoreBuffer_s1 && !sbEmpty_s1;
  // A pop frees the head slot in the same cycle, so a full buffer can still accept.
  assign do_push = pushStore_s1 && (!sbFull_s1 || popStoreBuffer_s1);

  always_ff @(posedge Phi1 or posedge Reset_s1) begin
    if (Reset_s1) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
      if (pushStore_s1 && sbFull_s1 && !popStoreBuffer_s1) overflow_q <= 1'b1;
    end
  end

  // Entry storage is deliberately not reset; count gates every read.
  always_ff @(posedge Phi1) begin
    if (do_push) begin
      addr_mem[wr_ptr_q] <= pushAddr_s1;
      data_mem[wr_ptr_q] <= pushData_s1;
    end
  end

  assign storeBufAddr_s1w = sbEmpty_s1 ? '0 : addr_mem[rd_ptr_q];
  assign storeBufData_s1w = sbEmpty_s1 ? '0 : data_mem[rd_ptr_q];

`ifdef STORE_BUF_FWD_EN
  sbMatch #(
    .DEPTH (DEPTH),
    .EW    (EW),
    .DW    (DW),
    .PW    (PW),
    .CW    (CW)
  ) u_match (
    .addrs     (addr_mem),
    .datas     (data_mem),
    .rd_ptr    (rd_ptr_q),
    .count     (count_q),
    .load_addr (loadAddr_s1),
    .hit       (fwdHit_s1),
    .data      (fwdData_s1)
  );
`else
  logic unused_load_addr;
  assign unused_load_addr = ^loadAddr_s1;
  assign fwdHit_s1        = 1'b0;
  assign fwdData_s1       = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4).
// Forwarding checks expect live hits only when STORE_BUF_FWD_EN is defined.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [34:0] push_addr;
  logic [31:0] push_data;
  logic        pop;
  logic [34:0] head_addr;
  logic [31:0] head_data;
  logic        empty, full, overflow;
  logic [2:0]  count;
  logic [29:0] load_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  int total = 0;
  int bad   = 0;

  store_buffer dut (
    .Phi1              (clk),
    .Reset_s1          (rst),
    .pushStore_s1      (push),
    .pushAddr_s1       (push_addr),
    .pushData_s1       (push_data),
    .popStoreBuffer_s1 (pop),
    .storeBufAddr_s1w  (head_addr),
    .storeBufData_s1w  (head_data),
    .sbEmpty_s1        (empty),
    .sbFull_s1         (full),
    .sbCount_s1        (count),
    .sbOverflow_s1     (overflow),
    .loadAddr_s1       (load_addr),
    .fwdHit_s1         (fwd_hit),
    .fwdData_s1        (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1ns after the edge.
  task automatic cycle(input logic p, input logic [34:0] a, input logic [31:0] d, input logic q);
    push      = p;
    push_addr = a;
    push_data = d;
    pop       = q;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  function automatic logic [34:0] waddr(input logic [31:0] a);
    return {3'b010, a};
  endfunction

  logic fwd_en;

  initial begin
`ifdef STORE_BUF_FWD_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
    rst = 1'b1; push = 1'b0; pop = 1'b0;
    push_addr = '0; push_data = '0; load_addr = '0;
    #2;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_head_addr", 64'(head_addr), 64'd0);
    check("rst_head_data", 64'(head_data), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // First push visible next cycle
    cycle(1'b1, waddr(32'h0000_1000), 32'hDEAD_BEEF, 1'b0);
    check("p1_head_addr", 64'(head_addr), 64'h2_0000_1000);
    check("p1_head_data", 64'(head_data), 64'hDEAD_BEEF);
    check("p1_count", 64'(count), 64'd1);
    check("p1_empty", 64'(empty), 64'd0);

    // Fill, then overflow
    cycle(1'b1, waddr(32'h0000_1004), 32'h11, 1'b0);
    cycle(1'b1, waddr(32'h0000_1008), 32'h22, 1'b0);
    check("p3_full", 64'(full), 64'd0);
    cycle(1'b1, waddr(32'h0000_100C), 32'h33, 1'b0);
    check("p4_full", 64'(full), 64'd1);
    check("p4_count", 64'(count), 64'd4);
    cycle(1'b1, waddr(32'h0000_1010), 32'h44, 1'b0);
    check("p5_count", 64'(count), 64'd4);
    check("p5_ovf", 64'(overflow), 64'd1);
    check("p5_head_addr", 64'(head_addr), 64'h2_0000_1000);
    check("p5_head_data", 64'(head_data), 64'hDEAD_BEEF);

    // Push+pop while full
    cycle(1'b1, waddr(32'h0000_1014), 32'h55, 1'b1);
    check("pp_count", 64'(count), 64'd4);
    check("pp_head", 64'(head_data), 64'h11);
    cycle(1'b0, '0, '0, 1'b1);
    check("drain1", 64'(head_data), 64'h22);
    cycle(1'b0, '0, '0, 1'b1);
    check("drain2", 64'(head_data), 64'h33);
    cycle(1'b0, '0, '0, 1'b1);
    check("drain3", 64'(head_data), 64'h55);
    check("drain3_addr", 64'(head_addr), 64'h2_0000_1014);
    cycle(1'b0, '0, '0, 1'b1);
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_head_zero", 64'(head_data), 64'd0);

    // Pop when empty is ignored; overflow is sticky
    cycle(1'b0, '0, '0, 1'b1);
    check("pop_empty_count", 64'(count), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);
    rst = 1'b1;
    #1;
    check("ovf_cleared", 64'(overflow), 64'd0);
    rst = 1'b0;

    // Push+pop while empty enqueues only
    cycle(1'b1, waddr(32'h0000_3000), 32'hAA, 1'b1);
    check("pp_empty_count", 64'(count), 64'd1);
    check("pp_empty_head", 64'(head_data), 64'hAA);
    cycle(1'b0, '0, '0, 1'b1);

    // Six push/pop pairs wrap the pointers
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, waddr(32'h0000_4000 + 32'(k * 4)), 32'h100 + 32'(k), 1'b0);
      check($sformatf("wrap_head%0d", k), 64'(head_data), 64'h100 + 64'(k));
      cycle(1'b0, '0, '0, 1'b1);
    end
    check("wrap_empty", 64'(empty), 64'd1);

    // Forwarding: youngest word store wins; byte stores never forward
    cycle(1'b1, waddr(32'h0000_2000), 32'd1, 1'b0);
    cycle(1'b1, waddr(32'h0000_2000), 32'd2, 1'b0);
    load_addr = 30'h800;
    #1;
    check("fwd_hit", 64'(fwd_hit), 64'(fwd_en));
    check("fwd_data", 64'(fwd_data), fwd_en ? 64'd2 : 64'd0);
    load_addr = 30'h801;
    #1;
    check("fwd_miss", 64'(fwd_hit), 64'd0);
    load_addr = 30'h800;
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b1, {3'b000, 32'h0000_2000}, 32'd3, 1'b0);
    check("fwd_byte_hit", 64'(fwd_hit), 64'd0);
    check("fwd_byte_data", 64'(fwd_data), 64'd0);
    cycle(1'b0, '0, '0, 1'b1);

    // Asynchronous reset between edges with 3 entries held
    cycle(1'b1, waddr(32'h0000_5000), 32'h1, 1'b0);
    cycle(1'b1, waddr(32'h0000_5004), 32'h2, 1'b0);
    cycle(1'b1, waddr(32'h0000_2000), 32'h3, 1'b0);
    check("mid_count3", 64'(count), 64'd3);
    #2 rst = 1'b1;
    #1;
    check("mid_empty", 64'(empty), 64'd1);
    check("mid_count", 64'(count), 64'd0);
    check("mid_full", 64'(full), 64'd0);
    check("mid_head", 64'(head_addr), 64'd0);
    check("mid_fwd", 64'(fwd_hit), 64'd0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
